button_debounce: RTL and testbench
==================================

// Module: button_debounce
// PURPOSE
//  Conditions the raw push-button before it reaches the vga_driver 'button' input.
//  - Synchronises the asynchronous pad signal.
//  - Debounces it with a stable-time counter.
//  - Produces a clean level plus one-cycle press/release pulses.
//  - btn_level drives vga_driver.button; pulses are available for future message-paging logic.
// PARAMETERS
//  CNT_MAX   500000    cycles input must be stable to accept a change (20 ms @ 25 MHz); legal >= 2
//  LONG_MAX  25000000  cycles in PRESSED before btn_long fires (1 s @ 25 MHz); used only with macro
//  Counter widths = ceil(log2(max)), computed with the codebase log2 function.
// PORTS
//  clk          in   1  pixel clock, same clk as vga_driver
//  reset        in   1  asynchronous, active-low; 0 = reset
//  btn_in       in   1  raw button pad, asynchronous, bouncy, 1 = pressed
//  btn_level    out  1  debounced level; 1 in PRESSED and REL_WAIT
//  btn_press    out  1  one-cycle pulse on accepted press
//  btn_release  out  1  one-cycle pulse on accepted release
//  btn_long     out  1  one-cycle pulse on long hold (macro only; else constant 0)
// BEHAVIOUR
//  - Reset (reset=0): sync flops=0, state=IDLE, counters=0, long_done=0, all outputs 0. All regs async-cleared.
//  - Synchroniser: 2 flops, btn_in -> s1 -> s2. The FSM uses s2 only.
//  - FSM states (registered; all outputs registered):
//    IDLE: s2=1 -> PRESS_WAIT, cnt<=0.
//    PRESS_WAIT: s2=0 -> IDLE, cnt<=0 (glitch rejected).
//      s2=1 && cnt==CNT_MAX-1 -> PRESSED, btn_press<=1, lcnt<=0.
//      Else cnt<=cnt+1.
//    PRESSED: s2=0 -> REL_WAIT, cnt<=0.
//    REL_WAIT: s2=1 -> PRESSED (bounce; no pulse, lcnt held).
//      s2=0 && cnt==CNT_MAX-1 -> IDLE, btn_release<=1.
//      Else cnt<=cnt+1.
//  - Latency: raw edge sampled at edge 0 -> pulse high in the cycle after edge CNT_MAX+2 (2 sync + 1 detect + CNT_MAX-1 count).
//  - Pulses last exactly one clk and never overlap; press/release strictly alternate.
//  - Any s2 change during a WAIT state restarts debouncing. A glitch shorter than CNT_MAX stable cycles gives no pulse and no level change.
//  - cnt saturates by construction and never wraps. lcnt saturates at LONG_MAX-1.
//  - Reset mid-operation: immediate return to IDLE with outputs 0. If the button is held across reset release, a full debounce occurs, then exactly one btn_press.
// CONFIGURATION
//  Macro BUTTON_DEBOUNCE_LONG_EN.
//  - Defined:
//    - lcnt increments each cycle in PRESSED and holds in REL_WAIT.
//    - When lcnt==LONG_MAX-1 in PRESSED with s2=1 and long_done=0: btn_long<=1 for one cycle, long_done<=1.
//    - long_done clears on entering IDLE, so at most one btn_long per press.
//    - If s2=0 on the terminal cycle, the transition to REL_WAIT wins and btn_long is not asserted that cycle.
//  - Undefined: lcnt and long_done are not instantiated; btn_long is tied 0. All other behaviour is identical.
// TESTING (CNT_MAX=4, LONG_MAX=10 for sim)
//  - Reset: hold reset=0 with btn_in toggling -> all outputs 0. Release reset with btn_in=0 -> outputs stay 0.
//  - Clean press: btn_in 0->1 before edge 0, held -> btn_press=1 only in cycle after edge 6; btn_level=1 from then on.
//  - Bounce: btn_in pulses 1 for 2 cycles, 0 for 1, then 1 steady -> exactly one btn_press, 4 stable cycles after the last rise.
//  - Release bounce: from PRESSED, drop 1 cycle and return -> no btn_release, btn_level stays 1; then a clean drop -> one btn_release.
//  - Long hold (macro on): hold 20 cycles past btn_press -> one btn_long 10 cycles after btn_press, no second one. Macro off -> btn_long always 0.
//  - Reset mid-PRESS_WAIT, btn_in held 1 -> after reset release, one btn_press at CNT_MAX+2 edges after release.

Source files
------------

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Conditions the raw push-button pad before it reaches vga_driver.button.
// The pad is synchronised through two flops, then a four-state FSM accepts a
// level change only after the synchronised input has held the new value for
// CNT_MAX consecutive counted cycles. The FSM produces a clean debounced level
// and one-cycle press/release pulses.
//
// Optional feature (macro BUTTON_DEBOUNCE_LONG_EN): a long-hold counter that
// fires a single btn_long pulse once the button has been in PRESSED for
// LONG_MAX cycles. When the macro is undefined, btn_long is tied to 0.
//
// Parameters
//   CNT_MAX   stable cycles required to accept a change (legal >= 2)
//   LONG_MAX  cycles in PRESSED before btn_long fires (macro build only)
//
// Ports
//   clk          in  pixel clock, shared with vga_driver
//   reset        in  asynchronous, active-low reset
//   btn_in       in  raw, asynchronous, bouncy button pad (1 = pressed)
//   btn_level    out debounced level, 1 in PRESSED and REL_WAIT
//   btn_press    out one-cycle pulse on accepted press
//   btn_release  out one-cycle pulse on accepted release
//   btn_long     out one-cycle pulse on long hold (0 without the macro)
// -----------------------------------------------------------------------------
module button_debounce #(
  parameter int CNT_MAX  = 500000,
  parameter int LONG_MAX = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  // Ceiling log2; a value of 1 or less yields 0, widths are clamped below.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int CNT_W = (clog2(CNT_MAX) < 1) ? 1 : clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    PRESSED    = 2'd2,
    REL_WAIT   = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             s1_q;
  logic             s2_q;
  logic             level_q;
  logic             press_q;
  logic             release_q;

  // Two-flop synchroniser; only s2_q is allowed into the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_in;
      s2_q <= s1_q;
    end
  end

`ifdef BUTTON_DEBOUNCE_LONG_EN
  localparam int LONG_W = (clog2(LONG_MAX) < 1) ? 1 : clog2(LONG_MAX);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_MAX - 1);
  localparam logic [LONG_W-1:0] LONG_ONE  = LONG_W'(1);

  logic [LONG_W-1:0] lcnt_q;
  logic              long_done_q;
  logic              long_q;
`endif

  // Debounce FSM. Pulses default low each cycle so they last exactly one clk;
  // the level register tracks whether the next state is PRESSED/REL_WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
`ifdef BUTTON_DEBOUNCE_LONG_EN
      lcnt_q      <= '0;
      long_done_q <= 1'b0;
      long_q      <= 1'b0;
`endif
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef BUTTON_DEBOUNCE_LONG_EN
      long_q    <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (s2_q) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!s2_q) begin
            // Glitch shorter than the stable window: drop it silently.
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
`ifdef BUTTON_DEBOUNCE_LONG_EN
            lcnt_q  <= '0;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        PRESSED: begin
`ifdef BUTTON_DEBOUNCE_LONG_EN
          // A falling s2 on the terminal cycle suppresses the long pulse.
          if (s2_q && (lcnt_q == LONG_LAST) && !long_done_q) begin
            long_q      <= 1'b1;
            long_done_q <= 1'b1;
          end
          if (lcnt_q != LONG_LAST) begin
            lcnt_q <= lcnt_q + LONG_ONE;
          end
`endif
          if (!s2_q) begin
            state_q <= REL_WAIT;
            cnt_q   <= '0;
          end
        end

        REL_WAIT: begin
          if (s2_q) begin
            // Release bounce: resume PRESSED with the hold counter intact.
            state_q <= PRESSED;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            release_q   <= 1'b1;
`ifdef BUTTON_DEBOUNCE_LONG_EN
            long_done_q <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

`ifdef BUTTON_DEBOUNCE_LONG_EN
  assign btn_long = long_q;
`else
  assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// -----------------------------------------------------------------------------
// tb_button_debounce
//
// Directed and randomised stimulus for button_debounce with CNT_MAX=4 and
// LONG_MAX=10. The reference model describes the debouncer in terms of how
// long the synchronised input has disagreed with the accepted level, and how
// long the accepted press has been settled, rather than in FSM states.
// -----------------------------------------------------------------------------
module tb_button_debounce;

  localparam int CNT_MAX  = 4;
  localparam int LONG_MAX = 10;

  logic clk;
  logic reset;
  logic btn_in;
  logic btn_level;
  logic btn_press;
  logic btn_release;
  logic btn_long;

  int checks;
  int errors;

  // Reference model state.
  int m_s1, m_s2;   // input delayed by one and two edges
  int m_level;      // accepted level
  int m_run;        // consecutive edges the delayed input differed from m_level
  int m_hold;       // settled-pressed edges since the press, saturating
  int m_done;       // long pulse already issued for this press
  bit e_press, e_rel, e_long;

  button_debounce #(
    .CNT_MAX (CNT_MAX),
    .LONG_MAX(LONG_MAX)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_hold = 0; m_done = 0;
    e_press = 0; e_rel = 0; e_long = 0;
  endtask

  // One active clock edge with raw input b sampled.
  task automatic model_edge(input logic b);
    int s;
    s = m_s2;
    e_press = 0; e_rel = 0; e_long = 0;
    // A settled press (level high, no pending disagreement) accrues hold time.
    if (m_level == 1 && m_run == 0) begin
      if (s == 1 && m_hold == LONG_MAX - 1 && m_done == 0) begin
        e_long = 1;
        m_done = 1;
      end
      if (m_hold < LONG_MAX - 1) m_hold++;
    end
    // A change is accepted once it has persisted for CNT_MAX+1 sampled edges.
    if (s != m_level) begin
      m_run++;
      if (m_run == CNT_MAX + 1) begin
        m_run = 0;
        if (m_level == 0) begin
          m_level = 1; e_press = 1; m_hold = 0;
        end else begin
          m_level = 0; e_rel = 1; m_done = 0;
        end
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = int'(b);
  endtask

  function automatic logic exp_long();
`ifdef BUTTON_DEBOUNCE_LONG_EN
    return e_long;
`else
    return 1'b0;
`endif
  endfunction

  task automatic compare_model(input string tag);
    check({tag, ".level"},   btn_level,   m_level[0]);
    check({tag, ".press"},   btn_press,   e_press);
    check({tag, ".release"}, btn_release, e_rel);
    check({tag, ".long"},    btn_long,    exp_long());
  endtask

  task automatic step(input logic b, input string tag);
    btn_in = b;
    @(posedge clk);
    model_edge(b);
    #1;
    compare_model(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".level"},   btn_level,   1'b0);
    check({tag, ".press"},   btn_press,   1'b0);
    check({tag, ".release"}, btn_release, 1'b0);
    check({tag, ".long"},    btn_long,    1'b0);
  endtask

  initial begin
    int npress;
    int nlong;
    logic v;
    checks = 0;
    errors = 0;
    btn_in = 1'b0;
    reset  = 1'b0;
    model_reset();

    // Reset held with a toggling pad: everything stays low.
    #2;
    check_all_zero("reset_async");
    for (int i = 0; i < 6; i++) begin
      btn_in = i[0];
      @(posedge clk);
      #1;
      check_all_zero("reset_hold");
    end
    btn_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, "idle_after_reset");
    check_all_zero("idle_quiet");

    // Clean press: pulse after edge CNT_MAX+2, level high from then on.
    for (int k = 0; k < 27; k++) begin
      step(1'b1, "clean_press");
      check("clean_press.latency", btn_press, (k == CNT_MAX + 2));
      if (k >= CNT_MAX + 2) check("clean_press.level_hi", btn_level, 1'b1);
`ifdef BUTTON_DEBOUNCE_LONG_EN
      check("long_hold.single", btn_long, (k == CNT_MAX + 2 + LONG_MAX));
`else
      check("long_hold.off", btn_long, 1'b0);
`endif
    end

    // Release bounce: a one-cycle drop is rejected.
    step(1'b0, "rel_bounce");
    for (int k = 0; k < 10; k++) begin
      step(1'b1, "rel_bounce");
      check("rel_bounce.level", btn_level, 1'b1);
      check("rel_bounce.no_release", btn_release, 1'b0);
    end
    // Clean drop: exactly one release after the same latency.
    for (int k = 0; k < 10; k++) begin
      step(1'b0, "clean_release");
      check("clean_release.latency", btn_release, (k == CNT_MAX + 2));
      check("clean_release.no_long", btn_long, 1'b0);
    end
    check("clean_release.level_lo", btn_level, 1'b0);

    // Press bounce 1,1,0 then steady 1: one press, counted from the last rise.
    step(1'b1, "press_bounce");
    step(1'b1, "press_bounce");
    step(1'b0, "press_bounce");
    npress = 0;
    for (int k = 3; k < 16; k++) begin
      step(1'b1, "press_bounce");
      if (btn_press) npress++;
      check("press_bounce.latency", btn_press, (k == CNT_MAX + 5));
    end
    check("press_bounce.count", (npress == 1), 1'b1);
    for (int k = 0; k < 10; k++) step(1'b0, "drop");

    // Reset during PRESS_WAIT with the button held.
    for (int k = 0; k < 4; k++) step(1'b1, "pw_before_reset");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, "post_reset_press");
      check("post_reset_press.latency", btn_press, (k == CNT_MAX + 2));
    end
    for (int k = 0; k < 10; k++) step(1'b0, "drop2");

    // Randomised bursts of random length, including glitches and long holds.
    npress = 0;
    nlong  = 0;
    for (int b = 0; b < 80; b++) begin
      int len;
      v   = logic'($urandom_range(0, 1));
      len = (b % 7 == 3) ? int'($urandom_range(12, 24)) : int'($urandom_range(1, 8));
      for (int k = 0; k < len; k++) begin
        step(v, "random");
        check("random.no_overlap", (btn_press & btn_release), 1'b0);
        if (btn_press) npress++;
        if (btn_long) nlong++;
      end
    end
`ifndef BUTTON_DEBOUNCE_LONG_EN
    check("random.long_never", (nlong == 0), 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
